// File: rtl/picomem_dma_pkg.sv
// rtl/picomem_dma_pkg.sv - register offsets, CTRL bit positions and FSM encoding for picomem_dma
package picomem_dma_pkg;

  localparam logic [3:0] REG_SRC  = 4'h0;
  localparam logic [3:0] REG_DST  = 4'h4;
  localparam logic [3:0] REG_LEN  = 4'h8;
  localparam logic [3:0] REG_CTRL = 4'hC;

  localparam int CTRL_START  = 0;
  localparam int CTRL_BUSY   = 1;
  localparam int CTRL_DONE   = 2;
  localparam int CTRL_IRQ_EN = 3;
  localparam int CTRL_ABORT  = 4;
  localparam int CTRL_FILL   = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_NEXT = 2'd3
  } state_t;

  // Merge a write into an existing 32-bit value byte by byte.
  function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  wstrb);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) begin
      r[i*8 +: 8] = wstrb[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/picomem_dma_regs.sv
// rtl/picomem_dma_regs.sv - cfg register file, handshake and START/ABORT/DONE pulses (option PICOMEM_DMA_FILL_EN)
module picomem_dma_regs
  import picomem_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [3:0]       cfg_addr,
  input  logic [3:0]       cfg_wstrb,
  input  logic [31:0]      cfg_wdata,
  output logic [31:0]      cfg_rdata,
  input  logic             busy,
  input  logic             step,
  input  logic             done_set,
  input  logic             done_clr,
  output logic [31:0]      src,
  output logic [31:0]      dst,
  output logic [LEN_W-1:0] len,
  output logic             fill,
  output logic             start,
  output logic             abort_pend,
  output logic             irq
);

`ifdef PICOMEM_DMA_FILL_EN
  localparam logic [31:0] SRC_MASK = 32'hFFFF_FFFF;
`else
  localparam logic [31:0] SRC_MASK = 32'hFFFF_FFFC;
`endif
  localparam logic [31:0] DST_MASK = 32'hFFFF_FFFC;

  logic        done;
  logic        irq_en;
  logic        accept;
  logic        wr_acc;
  logic        rd_acc;
  logic        wr_ctrl;
  logic [3:0]  reg_off;
  logic [31:0] rd_val;
  logic        unused_addr_lsb;

  assign accept          = cfg_valid && !cfg_ready;
  assign wr_acc          = accept && (cfg_wstrb != 4'h0);
  assign rd_acc          = accept && (cfg_wstrb == 4'h0);
  assign reg_off         = {cfg_addr[3:2], 2'b00};
  assign wr_ctrl         = wr_acc && (reg_off == REG_CTRL) && cfg_wstrb[0];
  assign unused_addr_lsb = ^cfg_addr[1:0];

  // Read mux; BUSY comes straight from the FSM, START/ABORT always read 0
  always_comb begin
    rd_val = 32'h0;
    case (reg_off)
      REG_SRC: rd_val = src;
      REG_DST: rd_val = dst;
      REG_LEN: rd_val = 32'(len);
      default: begin
        rd_val[CTRL_BUSY]   = busy;
        rd_val[CTRL_DONE]   = done;
        rd_val[CTRL_IRQ_EN] = irq_en;
        rd_val[CTRL_FILL]   = fill;
      end
    endcase
  end

  // One-cycle cfg_ready pulse per access; rdata only meaningful with it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cfg_ready <= 1'b0;
      cfg_rdata <= 32'h0;
    end else begin
      cfg_ready <= accept;
      cfg_rdata <= rd_acc ? rd_val : 32'h0;
    end
  end

  // Address and count registers: cfg writes when idle, FSM steps while busy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src <= 32'h0;
      dst <= 32'h0;
      len <= '0;
    end else begin
      if (wr_acc && !busy && reg_off == REG_SRC)
        src <= apply_wstrb(src, cfg_wdata, cfg_wstrb) & SRC_MASK;
      else if (step && !fill)
        src <= src + 32'd4;
      if (wr_acc && !busy && reg_off == REG_DST)
        dst <= apply_wstrb(dst, cfg_wdata, cfg_wstrb) & DST_MASK;
      else if (step)
        dst <= dst + 32'd4;
      if (wr_acc && !busy && reg_off == REG_LEN)
        len <= LEN_W'(apply_wstrb(32'(len), cfg_wdata, cfg_wstrb));
      else if (step)
        len <= len - LEN_W'(1);
    end
  end

  // CTRL state: START pulse, sticky DONE (set beats clear), ABORT pending, registered irq
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start      <= 1'b0;
      done       <= 1'b0;
      irq_en     <= 1'b0;
      abort_pend <= 1'b0;
      irq        <= 1'b0;
    end else begin
      start <= wr_ctrl && cfg_wdata[CTRL_START] && !busy;
      if (wr_ctrl)
        irq_en <= cfg_wdata[CTRL_IRQ_EN];
      if (done_set)
        done <= 1'b1;
      else if (done_clr || (wr_ctrl && cfg_wdata[CTRL_DONE]))
        done <= 1'b0;
      if (done_set || !busy)
        abort_pend <= 1'b0;
      else if (wr_ctrl && cfg_wdata[CTRL_ABORT])
        abort_pend <= 1'b1;
      irq <= done && irq_en;
    end
  end

`ifdef PICOMEM_DMA_FILL_EN
  // FILL is a mode bit, only changeable between transfers
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      fill <= 1'b0;
    else if (wr_ctrl && !busy)
      fill <= cfg_wdata[CTRL_FILL];
  end
`else
  assign fill = 1'b0;
`endif

endmodule

// File: rtl/picomem_dma.sv
// rtl/picomem_dma.sv - PicoSoC word-copy DMA engine top (option PICOMEM_DMA_FILL_EN)
module picomem_dma
  import picomem_dma_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [3:0]  cfg_addr,
  input  logic [3:0]  cfg_wstrb,
  input  logic [31:0] cfg_wdata,
  output logic [31:0] cfg_rdata,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_addr,
  output logic [3:0]  m_wstrb,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  output logic        irq
);

  state_t           state;
  state_t           state_nxt;
  logic             gap;
  logic [31:0]      data_buf;
  logic [31:0]      src;
  logic [31:0]      dst;
  logic [LEN_W-1:0] len;
  logic             fill;
  logic             start;
  logic             abort_pend;
  logic             busy;
  logic             step;
  logic             done_set;
  logic             done_clr;

  assign busy = (state != ST_IDLE);

  picomem_dma_regs #(.LEN_W(LEN_W)) u_regs (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_addr   (cfg_addr),
    .cfg_wstrb  (cfg_wstrb),
    .cfg_wdata  (cfg_wdata),
    .cfg_rdata  (cfg_rdata),
    .busy       (busy),
    .step       (step),
    .done_set   (done_set),
    .done_clr   (done_clr),
    .src        (src),
    .dst        (dst),
    .len        (len),
    .fill       (fill),
    .start      (start),
    .abort_pend (abort_pend),
    .irq        (irq)
  );

  // State register; async reset drops m_valid immediately
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Read data buffer and the idle cycle inserted between a read beat and its write beat
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap      <= 1'b0;
      data_buf <= 32'h0;
    end else begin
      gap <= (state == ST_RD) && m_ready;
      if (state == ST_RD && m_ready)
        data_buf <= m_rdata;
    end
  end

  // Next-state and bus outputs; in FILL mode the SRC value is the write data
  always_comb begin
    state_nxt = state;
    m_valid   = 1'b0;
    m_addr    = 32'h0;
    m_wstrb   = 4'h0;
    m_wdata   = 32'h0;
    step      = 1'b0;
    done_set  = 1'b0;
    done_clr  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          if (len != '0) begin
            done_clr  = 1'b1;
            state_nxt = fill ? ST_WR : ST_RD;
          end else begin
            done_set  = 1'b1;
          end
        end
      end
      ST_RD: begin
        m_valid = 1'b1;
        m_addr  = {src[31:2], 2'b00};
        if (m_ready)
          state_nxt = ST_WR;
      end
      ST_WR: begin
        m_valid = !gap;
        m_addr  = dst;
        m_wstrb = 4'hF;
        m_wdata = fill ? src : data_buf;
        if (m_ready && !gap)
          state_nxt = ST_NEXT;
      end
      default: begin
        step = 1'b1;
        if (len == LEN_W'(1) || abort_pend) begin
          done_set  = 1'b1;
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = fill ? ST_WR : ST_RD;
        end
      end
    endcase
  end

endmodule
